rv0_ahb_arb: RTL and testbench

RV0_AHB_ARB -- requirements
Module: rv0_ahb_arb

---
 rtl/rv0_ahb_arb_pkg.sv | 28 ++
 rtl/rv0_ahb_arb_if.sv | 25 ++
 rtl/rv0_ahb_arb_port.sv | 84 ++++++++
 rtl/rv0_ahb_arb.sv | 152 +++++++++++++++
 tb/tb_rv0_ahb_arb.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/rv0_ahb_arb_pkg.sv
// Shared AHB protocol constants and the arbiter's port-state / port-id types.
// ahb_pkg is the protocol package; rv0_ahb_arb_pkg holds the core-side types.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic       HRESP_OKAY    = 1'b0;
endpackage

package rv0_ahb_arb_pkg;
  import ahb_pkg::*;

  typedef enum logic [1:0] {
    P_IDLE,
    P_HELD,
    P_DATA
  } port_state_e;

  typedef enum logic [1:0] {
    PORT_IFU,
    PORT_LSU,
    PORT_NONE
  } port_id_e;

  function automatic logic is_req(input logic hsel, input logic [1:0] htrans);
    return hsel && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  endfunction
endpackage

// File: rtl/rv0_ahb_arb_if.sv
// AHB-lite point-to-point bundle; requester drives address/control/write data,
// completer returns read data, ready and response.
interface ahb_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] haddr;
  logic [1:0]      htrans;
  logic            hwrite;
  logic [2:0]      hsize;
  logic [XLEN-1:0] hwdata;
  logic            hsel;
  logic [XLEN-1:0] hrdata;
  logic            hreadyout;
  logic            hresp;

  modport requester (
    output haddr, htrans, hwrite, hsize, hwdata, hsel,
    input  hrdata, hreadyout, hresp
  );

  modport completer (
    input  haddr, htrans, hwrite, hsize, hwdata, hsel,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/rv0_ahb_arb_port.sv
// One requester-side port of the arbiter: accept logic, hold register and the
// IDLE/HELD/DATA state that decides what this port's hreadyout shows.
module rv0_ahb_arb_port
  import ahb_pkg::*;
  import rv0_ahb_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            hsel_i,
  input  logic [1:0]      htrans_i,
  input  logic [XLEN-1:0] haddr_i,
  input  logic            hwrite_i,
  input  logic [2:0]      hsize_i,
  input  logic            mem_ready_i,
  input  logic            issue_i,
  output logic            hreadyout_o,
  output logic            cand_o,
  output logic            cand_live_o,
  output logic [XLEN-1:0] cand_haddr_o,
  output logic [1:0]      cand_htrans_o,
  output logic            cand_hwrite_o,
  output logic [2:0]      cand_hsize_o
);
  port_state_e     state_q, state_d;
  logic [XLEN-1:0] haddr_q;
  logic [1:0]      htrans_q;
  logic            hwrite_q;
  logic [2:0]      hsize_q;
  logic            held;
  logic            accept;

  // Memory ready reaches this port's ready only while it owns the data phase.
  always_comb begin
    hreadyout_o = 1'b1;
    if (!rst_i) begin
      case (state_q)
        P_HELD:  hreadyout_o = 1'b0;
        P_DATA:  hreadyout_o = mem_ready_i;
        default: hreadyout_o = 1'b1;
      endcase
    end
  end

  assign accept      = !rst_i && hreadyout_o && is_req(hsel_i, htrans_i);
  assign held        = !rst_i && (state_q == P_HELD);
  assign cand_o      = held || accept;
  assign cand_live_o = accept;

  assign cand_haddr_o  = held ? haddr_q  : haddr_i;
  assign cand_htrans_o = held ? htrans_q : htrans_i;
  assign cand_hwrite_o = held ? hwrite_q : hwrite_i;
  assign cand_hsize_o  = held ? hsize_q  : hsize_i;

  always_comb begin
    state_d = state_q;
    if (issue_i) begin
      state_d = P_DATA;
    end else if (accept) begin
      state_d = P_HELD;
    end else if (state_q == P_DATA && mem_ready_i) begin
      state_d = P_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= P_IDLE;
      haddr_q  <= '0;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept && !issue_i) begin
        haddr_q  <= haddr_i;
        htrans_q <= htrans_i;
        hwrite_q <= hwrite_i;
        hsize_q  <= hsize_i;
      end
    end
  end
endmodule

// File: rtl/rv0_ahb_arb.sv
// Two-requester (IFU, LSU) AHB-lite arbiter onto one memory port.
// Define RV0_AHB_ARB_RR_EN for round-robin; default is fixed LSU-over-IFU priority.
module rv0_ahb_arb
  import ahb_pkg::*;
  import rv0_ahb_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  ahb_if.completer   ifu_if,
  ahb_if.completer   lsu_if,
  ahb_if.requester   mem_if,
  output logic [1:0] arb_gnt_o
);
  // Index 0 is the IFU, index 1 the LSU, matching the arb_gnt_o bit order.
  logic [1:0]      p_hsel, p_hwrite, p_ready, p_cand, p_live, p_chwrite, issue;
  logic [1:0]      p_htrans [2];
  logic [1:0]      p_chtrans [2];
  logic [2:0]      p_hsize [2];
  logic [2:0]      p_chsize [2];
  logic [XLEN-1:0] p_haddr [2];
  logic [XLEN-1:0] p_chaddr [2];
  port_id_e        win, data_owner_q, data_owner_d, prev_q, prev_d;
  logic            sel;

  assign p_hsel     = {lsu_if.hsel, ifu_if.hsel};
  assign p_hwrite   = {lsu_if.hwrite, ifu_if.hwrite};
  assign p_htrans[0] = ifu_if.htrans;
  assign p_htrans[1] = lsu_if.htrans;
  assign p_hsize[0]  = ifu_if.hsize;
  assign p_hsize[1]  = lsu_if.hsize;
  assign p_haddr[0]  = ifu_if.haddr;
  assign p_haddr[1]  = lsu_if.haddr;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_port
    rv0_ahb_arb_port #(.XLEN(XLEN)) u_port (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .hsel_i        (p_hsel[gi]),
      .htrans_i      (p_htrans[gi]),
      .haddr_i       (p_haddr[gi]),
      .hwrite_i      (p_hwrite[gi]),
      .hsize_i       (p_hsize[gi]),
      .mem_ready_i   (mem_if.hreadyout),
      .issue_i       (issue[gi]),
      .hreadyout_o   (p_ready[gi]),
      .cand_o        (p_cand[gi]),
      .cand_live_o   (p_live[gi]),
      .cand_haddr_o  (p_chaddr[gi]),
      .cand_htrans_o (p_chtrans[gi]),
      .cand_hwrite_o (p_chwrite[gi]),
      .cand_hsize_o  (p_chsize[gi])
    );
  end

`ifdef RV0_AHB_ARB_RR_EN
  port_id_e last_q, last_d;
`endif

  always_comb begin
    issue = 2'b00;
    if (!rst_i && mem_if.hreadyout) begin
`ifdef RV0_AHB_ARB_RR_EN
      if (&p_cand) begin
        issue = (last_q == PORT_IFU) ? 2'b10 : 2'b01;
      end else begin
        issue = p_cand;
      end
`else
      issue = p_cand[1] ? 2'b10 : p_cand;
`endif
    end
  end

  always_comb begin
    win = PORT_NONE;
    if (issue[1]) begin
      win = PORT_LSU;
    end else if (issue[0]) begin
      win = PORT_IFU;
    end
  end

  assign sel       = issue[1];
  assign arb_gnt_o = issue;

  // A burst may keep SEQ only if it continues live from the port that issued last.
  always_comb begin
    mem_if.haddr  = '0;
    mem_if.htrans = HTRANS_IDLE;
    mem_if.hwrite = 1'b0;
    mem_if.hsize  = '0;
    mem_if.hsel   = 1'b1;
    if (win != PORT_NONE) begin
      mem_if.haddr  = p_chaddr[sel];
      mem_if.hwrite = p_chwrite[sel];
      mem_if.hsize  = p_chsize[sel];
      mem_if.htrans = (p_live[sel] && p_chtrans[sel] == HTRANS_SEQ && prev_q == win)
                      ? HTRANS_SEQ : HTRANS_NONSEQ;
    end
  end

  always_comb begin
    case (data_owner_q)
      PORT_IFU: mem_if.hwdata = ifu_if.hwdata;
      PORT_LSU: mem_if.hwdata = lsu_if.hwdata;
      default:  mem_if.hwdata = '0;
    endcase
  end

  assign ifu_if.hrdata    = mem_if.hrdata;
  assign lsu_if.hrdata    = mem_if.hrdata;
  assign ifu_if.hresp     = (data_owner_q == PORT_IFU) ? mem_if.hresp : HRESP_OKAY;
  assign lsu_if.hresp     = (data_owner_q == PORT_LSU) ? mem_if.hresp : HRESP_OKAY;
  assign ifu_if.hreadyout = p_ready[0];
  assign lsu_if.hreadyout = p_ready[1];

  always_comb begin
    data_owner_d = data_owner_q;
    prev_d       = prev_q;
    if (mem_if.hreadyout) begin
      data_owner_d = win;
    end
    if (win != PORT_NONE) begin
      prev_d = win;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_owner_q <= PORT_NONE;
      prev_q       <= PORT_NONE;
    end else begin
      data_owner_q <= data_owner_d;
      prev_q       <= prev_d;
    end
  end

`ifdef RV0_AHB_ARB_RR_EN
  assign last_d = (win != PORT_NONE) ? win : last_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= PORT_IFU;
    end else begin
      last_q <= last_d;
    end
  end
`endif
endmodule

// File: tb/tb_rv0_ahb_arb.sv
// Directed, table-driven bench for rv0_ahb_arb: one row per clock cycle,
// plus hand-written sequences for response routing and reset with a held request.
module tb_rv0_ahb_arb;
  import ahb_pkg::*;

  localparam logic [1:0]  ID = 2'b00;
  localparam logic [1:0]  NS = 2'b10;
  localparam logic [1:0]  SQ = 2'b11;
  localparam logic [31:0] IW = 32'h1111_1111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] gnt;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  ahb_if #(.XLEN(32)) ifu_bus ();
  ahb_if #(.XLEN(32)) lsu_bus ();
  ahb_if #(.XLEN(32)) mem_bus ();

  rv0_ahb_arb #(.XLEN(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .ifu_if    (ifu_bus),
    .lsu_if    (lsu_bus),
    .mem_if    (mem_bus),
    .arb_gnt_o (gnt)
  );

  typedef struct {
    logic        rst;
    logic        isel;
    logic [1:0]  itr;
    logic [31:0] iad;
    logic [1:0]  ltr;
    logic [31:0] lad;
    logic        lwr;
    logic [31:0] lwd;
    logic        mrdy;
    logic [1:0]  gnt;
    logic [1:0]  tr;
    logic [31:0] ad;
    logic        irdy;
    logic        lrdy;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic isel, input logic [1:0] itr, input logic [31:0] iad,
                     input logic [1:0] ltr, input logic [31:0] lad, input logic lwr, input logic [31:0] lwd,
                     input logic mrdy, input logic [1:0] egnt, input logic [1:0] etr, input logic [31:0] ead,
                     input logic eirdy, input logic elrdy, input logic [31:0] ewd);
    vec_t v;
    v.rst = r;  v.isel = isel; v.itr = itr; v.iad = iad;
    v.ltr = ltr; v.lad = lad; v.lwr = lwr; v.lwd = lwd; v.mrdy = mrdy;
    v.gnt = egnt; v.tr = etr; v.ad = ead; v.irdy = eirdy; v.lrdy = elrdy; v.wd = ewd;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic isel, input logic [1:0] itr, input logic [31:0] iad,
                       input logic [1:0] ltr, input logic [31:0] lad, input logic lwr, input logic [31:0] lwd,
                       input logic mrdy);
    rst              = r;
    ifu_bus.hsel     = isel;
    ifu_bus.htrans   = itr;
    ifu_bus.haddr    = iad;
    ifu_bus.hwrite   = 1'b0;
    ifu_bus.hsize    = 3'd2;
    ifu_bus.hwdata   = IW;
    lsu_bus.hsel     = 1'b1;
    lsu_bus.htrans   = ltr;
    lsu_bus.haddr    = lad;
    lsu_bus.hwrite   = lwr;
    lsu_bus.hsize    = 3'd2;
    lsu_bus.hwdata   = lwd;
    mem_bus.hreadyout = mrdy;
    mem_bus.hrdata   = 32'h0;
    mem_bus.hresp    = HRESP_OKAY;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    // Reset with a live IFU request: nothing may be issued while in reset.
    drive(1, 1, NS, 32'h100, ID, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    check("reset gnt", gnt, 2'b00);
    check("reset htrans", mem_bus.htrans, HTRANS_IDLE);
    check("reset ifu ready", ifu_bus.hreadyout, 1'b1);
    check("reset lsu ready", lsu_bus.hreadyout, 1'b1);
    check("reset hwdata", mem_bus.hwdata, 32'h0);
    check("reset hsel", mem_bus.hsel, 1'b1);

    // IFU alone: NONSEQ then SEQ, zero-wait memory
    add(0,1,NS,32'h0,   ID,0,0,0,1,  2'b01,NS,32'h0,  1,1,32'h0);
    add(0,1,SQ,32'h4,   ID,0,0,0,1,  2'b01,SQ,32'h4,  1,1,IW);
    add(0,1,ID,0,       ID,0,0,0,1,  2'b00,ID,32'h0,  1,1,IW);
    add(0,1,ID,0,       ID,0,0,0,1,  2'b00,ID,32'h0,  1,1,32'h0);
    // Simultaneous IFU read / LSU write: LSU first, IFU one cycle later from hold
    add(0,1,NS,32'h100, NS,32'h2000,1,0,1,            2'b10,NS,32'h2000,1,1,32'h0);
    add(0,1,ID,0,       ID,0,0,32'hCAFE0001,1,        2'b01,NS,32'h100, 0,1,32'hCAFE0001);
    add(0,1,ID,0,       ID,0,0,0,1,  2'b00,ID,32'h0,  1,1,IW);
    add(0,1,ID,0,       ID,0,0,0,1,  2'b00,ID,32'h0,  1,1,32'h0);
    // Memory stall during IFU data phase while LSU requests 0x3000
    add(0,1,NS,32'h200, ID,0,0,0,1,  2'b01,NS,32'h200,1,1,32'h0);
    add(0,1,ID,0,       NS,32'h3000,0,0,0,            2'b00,ID,32'h0,  0,1,IW);
    add(0,1,ID,0,       ID,0,0,0,0,  2'b00,ID,32'h0,  0,0,IW);
    add(0,1,ID,0,       ID,0,0,0,1,  2'b10,NS,32'h3000,1,0,IW);
    add(0,1,ID,0,       ID,0,0,32'h5555AAAA,1,        2'b00,ID,32'h0,  1,1,32'h5555AAAA);
    add(0,1,ID,0,       ID,0,0,0,1,  2'b00,ID,32'h0,  1,1,32'h0);
    // LSU write data overlaps the IFU address phase
    add(0,1,ID,0,       NS,32'h2000,1,0,1,            2'b10,NS,32'h2000,1,1,32'h0);
    add(0,1,NS,32'h40,  ID,0,0,32'hDEADBEEF,1,        2'b01,NS,32'h40, 1,1,32'hDEADBEEF);
    add(0,1,ID,0,       ID,0,0,0,1,  2'b00,ID,32'h0,  1,1,IW);
    add(0,1,ID,0,       ID,0,0,0,1,  2'b00,ID,32'h0,  1,1,32'h0);
    // hsel low: not a request
    add(0,0,NS,32'h80,  ID,0,0,0,1,  2'b00,ID,32'h0,  1,1,32'h0);
    add(1,1,ID,0,       ID,0,0,0,1,  2'b00,ID,32'h0,  1,1,32'h0);
    // Both ports streaming SEQ bursts
    add(0,1,NS,32'h1000,NS,32'h4000,0,32'hA5,1,       2'b10,NS,32'h4000,1,1,32'h0);
`ifdef RV0_AHB_ARB_RR_EN
    add(0,1,SQ,32'h1004,SQ,32'h4004,0,32'hA5,1,       2'b01,NS,32'h1000,0,1,32'hA5);
    add(0,1,SQ,32'h1004,SQ,32'h4008,0,32'hA5,1,       2'b10,NS,32'h4004,1,0,IW);
    add(0,1,SQ,32'h1008,SQ,32'h4008,0,32'hA5,1,       2'b01,NS,32'h1004,0,1,32'hA5);
    add(0,1,SQ,32'h1008,SQ,32'h400C,0,32'hA5,1,       2'b10,NS,32'h4008,1,0,IW);
    add(0,1,ID,0,       ID,0,0,32'hA5,1,              2'b01,NS,32'h1008,0,1,32'hA5);
    add(0,1,ID,0,       ID,0,0,0,1,  2'b00,ID,32'h0,  1,1,IW);
`else
    add(0,1,SQ,32'h1004,SQ,32'h4004,0,32'hA5,1,       2'b10,SQ,32'h4004,0,1,32'hA5);
    add(0,1,SQ,32'h1004,SQ,32'h4008,0,32'hA5,1,       2'b10,SQ,32'h4008,0,1,32'hA5);
    add(0,1,ID,0,       ID,0,0,32'hA5,1,              2'b01,NS,32'h1000,0,1,32'hA5);
    add(0,1,ID,0,       ID,0,0,0,1,  2'b00,ID,32'h0,  1,1,IW);
`endif
    add(0,1,ID,0,       ID,0,0,0,1,  2'b00,ID,32'h0,  1,1,32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].isel, vecs[i].itr, vecs[i].iad, vecs[i].ltr, vecs[i].lad,
            vecs[i].lwr, vecs[i].lwd, vecs[i].mrdy);
      #2;
      $display("row %0d: gnt=%b htrans=%0d haddr=%h hwdata=%h ifu_rdy=%b lsu_rdy=%b",
               i, gnt, mem_bus.htrans, mem_bus.haddr, mem_bus.hwdata,
               ifu_bus.hreadyout, lsu_bus.hreadyout);
      check($sformatf("row%0d gnt", i), gnt, vecs[i].gnt);
      check($sformatf("row%0d htrans", i), mem_bus.htrans, vecs[i].tr);
      check($sformatf("row%0d haddr", i), mem_bus.haddr, vecs[i].ad);
      check($sformatf("row%0d ifu_rdy", i), ifu_bus.hreadyout, vecs[i].irdy);
      check($sformatf("row%0d lsu_rdy", i), lsu_bus.hreadyout, vecs[i].lrdy);
      check($sformatf("row%0d hwdata", i), mem_bus.hwdata, vecs[i].wd);
    end

    // Control forwarding, read data broadcast and response routing to the owner
    @(negedge clk);
    drive(0, 1, ID, 0, NS, 32'h2400, 1, 0, 1);
    #2;
    $display("resp seq issue: gnt=%b hwrite=%b hsize=%0d", gnt, mem_bus.hwrite, mem_bus.hsize);
    check("lsu issue gnt", gnt, 2'b10);
    check("lsu hwrite fwd", mem_bus.hwrite, 1'b1);
    check("lsu hsize fwd", mem_bus.hsize, 3'd2);
    @(negedge clk);
    drive(0, 1, ID, 0, ID, 0, 0, 0, 1);
    mem_bus.hresp  = 1'b1;
    mem_bus.hrdata = 32'h1234_5678;
    #2;
    $display("resp seq data: ifu_hresp=%b lsu_hresp=%b hrdata=%h", ifu_bus.hresp, lsu_bus.hresp, lsu_bus.hrdata);
    check("lsu hresp", lsu_bus.hresp, 1'b1);
    check("ifu hresp", ifu_bus.hresp, 1'b0);
    check("ifu hrdata", ifu_bus.hrdata, 32'h1234_5678);
    check("lsu hrdata", lsu_bus.hrdata, 32'h1234_5678);

    // Reset while IFU is held: the held address must never reach memory
    @(negedge clk);
    drive(0, 1, NS, 32'h100, ID, 0, 0, 0, 0);
    #2;
    $display("held seq accept: gnt=%b ifu_rdy=%b", gnt, ifu_bus.hreadyout);
    check("held accept gnt", gnt, 2'b00);
    check("held accept ifu_rdy", ifu_bus.hreadyout, 1'b1);
    @(negedge clk);
    drive(1, 1, ID, 0, ID, 0, 0, 0, 1);
    #2;
    $display("held seq reset: gnt=%b htrans=%0d", gnt, mem_bus.htrans);
    check("rst held gnt", gnt, 2'b00);
    check("rst held htrans", mem_bus.htrans, HTRANS_IDLE);
    check("rst held ifu_rdy", ifu_bus.hreadyout, 1'b1);
    check("rst held lsu_rdy", lsu_bus.hreadyout, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(0, 1, ID, 0, ID, 0, 0, 0, 1);
      #2;
      $display("post reset %0d: gnt=%b htrans=%0d haddr=%h", k, gnt, mem_bus.htrans, mem_bus.haddr);
      check($sformatf("post rst%0d gnt", k), gnt, 2'b00);
      check($sformatf("post rst%0d htrans", k), mem_bus.htrans, HTRANS_IDLE);
      check($sformatf("post rst%0d ifu_rdy", k), ifu_bus.hreadyout, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
